// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore control FSM for a multicycle MIPS datapath. Sequences each
//   instruction over 3-5 cycles through a shared ALU and unified memory,
//   driving mux selects, write enables and the ALU op class.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4 (waits on mem_ready)
//   DECODE   | register read, branch target into ALUOut, dispatch on op
//   MEMADR   | lw/sw effective address A + imm
//   MEMRD    | memory read at ALUOut (waits on mem_ready)
//   MEMWB    | load data into rt
//   MEMWR    | memory write at ALUOut (waits on mem_ready)
//   EXECUTE  | R-type ALU operation
//   ALUWB    | R-type result into rd
//   BRANCH   | compare A-B, redirect PC on beq/bne outcome
//   ADDIEX   | A + imm
//   ADDIWB   | addi result into rt
//   JUMP     | PC <= jump target
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   op[5:0]           opcode from the IR
//   zero              ALU zero flag
//   mem_ready         memory access completes this cycle
//   iord .. pc_src    datapath selects / write strobes
//   pc_en             PC load
//   instr_done        pulse in an instruction's last cycle
//   illegal_op        pulse when DECODE sees an unsupported opcode
//   state_o[3:0]      current state, for debug
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_BNE   = 1'b1,
  parameter bit SUPPORT_ADDI  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;
  state_t w_next;

  logic w_rdy;
  logic w_ir_write;
  logic w_mem_write;
  logic w_reg_write;
  logic w_pc_write;
  logic w_branch;
  logic w_is_bne;

  assign w_rdy = mem_ready | !MEM_HANDSHAKE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    iord        = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    w_reg_write = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    w_pc_write  = 1'b0;
    w_branch    = 1'b0;
    w_is_bne    = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b01;
        w_ir_write = w_rdy;
        w_pc_write = w_rdy;
        w_next     = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (op == OP_LW || op == OP_SW)                    w_next = S_MEMADR;
        else if (op == OP_RTYPE)                           w_next = S_EXECUTE;
        else if (op == OP_BEQ || (op == OP_BNE && SUPPORT_BNE)) w_next = S_BRANCH;
        else if (op == OP_ADDI && SUPPORT_ADDI)            w_next = S_ADDIEX;
        else if (op == OP_J)                               w_next = S_JUMP;
        else begin
          // Unsupported opcode retires immediately without touching state.
          w_next     = S_FETCH;
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
      end
      S_MEMWR: begin
        // Strobe held until memory accepts the write.
        iord        = 1'b1;
        w_mem_write = 1'b1;
        instr_done  = w_rdy;
        w_next      = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst     = 1'b1;
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        w_branch   = 1'b1;
        w_is_bne   = (op == OP_BNE) && SUPPORT_BNE;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_reg_write = 1'b1;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        w_pc_write = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        // Unreachable encodings: look like FETCH with no enables, recover.
        alu_src_b = 2'b01;
      end
    endcase
  end

  // Enables are gated by reset so nothing is written while it is held.
  assign ir_write  = w_ir_write  & rst_n;
  assign mem_write = w_mem_write & rst_n;
  assign reg_write = w_reg_write & rst_n;
  assign pc_en     = (w_pc_write | (w_branch & (zero ^ w_is_bne))) & rst_n;
  assign state_o   = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       iord0, mw0, irw0, rd0, m2r0, rw0, asa0, pcen0, done0, ill0;
  logic [1:0] asb0, aop0, psrc0;
  logic [3:0] st0;
  logic       iord1, mw1, irw1, rd1, m2r1, rw1, asa1, pcen1, done1, ill1;
  logic [1:0] asb1, aop1, psrc1;
  logic [3:0] st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord0), .mem_write(mw0), .ir_write(irw0), .reg_dst(rd0),
    .mem_to_reg(m2r0), .reg_write(rw0), .alu_src_a(asa0), .alu_src_b(asb0),
    .alu_op(aop0), .pc_src(psrc0), .pc_en(pcen0), .instr_done(done0),
    .illegal_op(ill0), .state_o(st0)
  );

  // Reduced-feature variant: no bne, no addi, no memory handshake.
  multicycle_controller #(
    .MEM_HANDSHAKE(1'b0), .SUPPORT_BNE(1'b0), .SUPPORT_ADDI(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord1), .mem_write(mw1), .ir_write(irw1), .reg_dst(rd1),
    .mem_to_reg(m2r1), .reg_write(rw1), .alu_src_a(asa1), .alu_src_b(asb1),
    .alu_op(aop1), .pc_src(psrc1), .pc_en(pcen1), .instr_done(done1),
    .illegal_op(ill1), .state_o(st1)
  );

  logic [19:0] act0, act1;
  assign act0 = {st0, iord0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, aop0, psrc0, pcen0, done0, ill0};
  assign act1 = {st1, iord1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, psrc1, pcen1, done1, ill1};

  function automatic logic [19:0] pk(
    input logic [3:0] st, input logic io, input logic mw, input logic irw,
    input logic rd, input logic m2r, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] psrc,
    input logic pcen, input logic done, input logic ill);
    return {st, io, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pcen, done, ill};
  endfunction

  //                                 st io mw irw rd m2r rw asa asb    aop    psrc  pcen done ill
  localparam logic [19:0] E_RST     = pk(0, 0,0,0, 0,0,0, 0, 2'b01, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_FETCH_R = pk(0, 0,0,1, 0,0,0, 0, 2'b01, 2'b00, 2'b00, 1,0,0);
  localparam logic [19:0] E_FETCH_W = pk(0, 0,0,0, 0,0,0, 0, 2'b01, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_DEC     = pk(1, 0,0,0, 0,0,0, 0, 2'b11, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_DEC_ILL = pk(1, 0,0,0, 0,0,0, 0, 2'b11, 2'b00, 2'b00, 0,1,1);
  localparam logic [19:0] E_MEMADR  = pk(2, 0,0,0, 0,0,0, 1, 2'b10, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_MEMRD   = pk(3, 1,0,0, 0,0,0, 0, 2'b00, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_MEMWB   = pk(4, 0,0,0, 0,1,1, 0, 2'b00, 2'b00, 2'b00, 0,1,0);
  localparam logic [19:0] E_MEMWR_W = pk(5, 1,1,0, 0,0,0, 0, 2'b00, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_MEMWR_D = pk(5, 1,1,0, 0,0,0, 0, 2'b00, 2'b00, 2'b00, 0,1,0);
  localparam logic [19:0] E_EXEC    = pk(6, 0,0,0, 0,0,0, 1, 2'b00, 2'b10, 2'b00, 0,0,0);
  localparam logic [19:0] E_ALUWB   = pk(7, 0,0,0, 1,0,1, 0, 2'b00, 2'b00, 2'b00, 0,1,0);
  localparam logic [19:0] E_BR_T    = pk(8, 0,0,0, 0,0,0, 1, 2'b00, 2'b01, 2'b01, 1,1,0);
  localparam logic [19:0] E_BR_N    = pk(8, 0,0,0, 0,0,0, 1, 2'b00, 2'b01, 2'b01, 0,1,0);
  localparam logic [19:0] E_ADDIEX  = pk(9, 0,0,0, 0,0,0, 1, 2'b10, 2'b00, 2'b00, 0,0,0);
  localparam logic [19:0] E_ADDIWB  = pk(10,0,0,0, 0,0,1, 0, 2'b00, 2'b00, 2'b00, 0,1,0);
  localparam logic [19:0] E_JUMP    = pk(11,0,0,0, 0,0,0, 0, 2'b00, 2'b00, 2'b10, 1,1,0);

  typedef struct {
    bit          sel;
    logic [19:0] v;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  logic [19:0] m_act;

  // Monitor: every cycle with a pending expectation, compare the selected DUT.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_act = m_e.sel ? act1 : act0;
      checks++;
      if (m_act !== m_e.v) begin
        errors++;
        $display("FAIL %s: dut%0d got %h expected %h", m_e.tag, m_e.sel, m_act, m_e.v);
      end
    end
  end

  // Drive one cycle's inputs just after the edge and queue that cycle's outputs.
  task automatic step(input bit sel, input logic rst, input logic [5:0] o,
                      input logic z, input logic r, input logic [19:0] v,
                      input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    op        = o;
    zero      = z;
    mem_ready = r;
    e.sel = sel;
    e.v   = v;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0; op = 6'b0; zero = 1'b0; mem_ready = 1'b0;

    step(0, 0, 6'b000000, 0, 1, E_RST, "reset");
    step(0, 0, 6'b000000, 0, 1, E_RST, "reset_gate");

    // R-type: 0,1,6,7
    step(0, 1, 6'b000000, 0, 1, E_FETCH_R, "r_fetch");
    step(0, 1, 6'b000000, 0, 1, E_DEC,     "r_dec");
    step(0, 1, 6'b000000, 0, 1, E_EXEC,    "r_exec");
    step(0, 1, 6'b000000, 0, 1, E_ALUWB,   "r_wb");
    // lw with two wait cycles in MEMRD
    step(0, 1, 6'b100011, 0, 1, E_FETCH_R, "lw_fetch");
    step(0, 1, 6'b100011, 0, 1, E_DEC,     "lw_dec");
    step(0, 1, 6'b100011, 0, 1, E_MEMADR,  "lw_adr");
    step(0, 1, 6'b100011, 0, 0, E_MEMRD,   "lw_rd_w1");
    step(0, 1, 6'b100011, 0, 0, E_MEMRD,   "lw_rd_w2");
    step(0, 1, 6'b100011, 0, 1, E_MEMRD,   "lw_rd_ok");
    step(0, 1, 6'b100011, 0, 1, E_MEMWB,   "lw_wb");
    // sw with one wait cycle in MEMWR
    step(0, 1, 6'b101011, 0, 1, E_FETCH_R, "sw_fetch");
    step(0, 1, 6'b101011, 0, 1, E_DEC,     "sw_dec");
    step(0, 1, 6'b101011, 0, 1, E_MEMADR,  "sw_adr");
    step(0, 1, 6'b101011, 0, 0, E_MEMWR_W, "sw_wr_wait");
    step(0, 1, 6'b101011, 0, 1, E_MEMWR_D, "sw_wr_done");
    // fetch wait, then beq taken
    step(0, 1, 6'b000100, 0, 0, E_FETCH_W, "fetch_wait");
    step(0, 1, 6'b000100, 0, 1, E_FETCH_R, "beq1_fetch");
    step(0, 1, 6'b000100, 0, 1, E_DEC,     "beq1_dec");
    step(0, 1, 6'b000100, 1, 1, E_BR_T,    "beq_z1");
    step(0, 1, 6'b000100, 0, 1, E_FETCH_R, "beq0_fetch");
    step(0, 1, 6'b000100, 0, 1, E_DEC,     "beq0_dec");
    step(0, 1, 6'b000100, 0, 1, E_BR_N,    "beq_z0");
    step(0, 1, 6'b000101, 0, 1, E_FETCH_R, "bne0_fetch");
    step(0, 1, 6'b000101, 0, 1, E_DEC,     "bne0_dec");
    step(0, 1, 6'b000101, 0, 1, E_BR_T,    "bne_z0");
    step(0, 1, 6'b000101, 0, 1, E_FETCH_R, "bne1_fetch");
    step(0, 1, 6'b000101, 0, 1, E_DEC,     "bne1_dec");
    step(0, 1, 6'b000101, 1, 1, E_BR_N,    "bne_z1");
    // addi, j, illegal
    step(0, 1, 6'b001000, 0, 1, E_FETCH_R, "addi_fetch");
    step(0, 1, 6'b001000, 0, 1, E_DEC,     "addi_dec");
    step(0, 1, 6'b001000, 0, 1, E_ADDIEX,  "addi_ex");
    step(0, 1, 6'b001000, 0, 1, E_ADDIWB,  "addi_wb");
    step(0, 1, 6'b000010, 0, 1, E_FETCH_R, "j_fetch");
    step(0, 1, 6'b000010, 0, 1, E_DEC,     "j_dec");
    step(0, 1, 6'b000010, 0, 1, E_JUMP,    "j_jump");
    step(0, 1, 6'b111111, 0, 1, E_FETCH_R, "ill_fetch");
    step(0, 1, 6'b111111, 0, 1, E_DEC_ILL, "ill_dec");
    step(0, 1, 6'b111111, 0, 0, E_FETCH_W, "ill_back");
    // async reset while in MEMWR with mem_ready high
    step(0, 1, 6'b101011, 0, 1, E_FETCH_R, "swr_fetch");
    step(0, 1, 6'b101011, 0, 1, E_DEC,     "swr_dec");
    step(0, 1, 6'b101011, 0, 1, E_MEMADR,  "swr_adr");
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    chk("swr_in_memwr", st0, 4'd5);
    chk("swr_mw_pre", {3'b000, mw0}, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", st0, 4'd0);
    chk("async_en", {mw0, pcen0, irw0, rw0}, 4'b0000);
    step(0, 0, 6'b101011, 0, 1, E_RST, "rst_hold");

    // Reduced variant: handshake ignored, bne and addi illegal
    step(1, 1, 6'b000101, 0, 0, E_FETCH_R, "nb_fetch");
    step(1, 1, 6'b000101, 0, 0, E_DEC_ILL, "nb_bne_ill");
    step(1, 1, 6'b001000, 0, 0, E_FETCH_R, "na_fetch");
    step(1, 1, 6'b001000, 0, 0, E_DEC_ILL, "na_addi_ill");
    step(1, 1, 6'b101011, 0, 0, E_FETCH_R, "nh_fetch");
    step(1, 1, 6'b101011, 0, 0, E_DEC,     "nh_dec");
    step(1, 1, 6'b101011, 0, 0, E_MEMADR,  "nh_adr");
    step(1, 1, 6'b101011, 0, 0, E_MEMWR_D, "nh_wr");
    step(1, 1, 6'b000000, 0, 0, E_FETCH_R, "nh_back");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
